// File: rtl/action_ram.sv
// action_ram: simple dual-port RAM, read-first, registered output, synchronous clear
module action_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out <= '0;
        end else if (en) begin
            if (write_en) mem[wr_addr] <= data_in;
            data_out <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_action_ram.sv
// tb_action_ram: directed checks of reset, gating, read-first and full-range access
module tb_action_ram;
    logic        clk = 0;
    logic        rst = 0;
    logic        en = 0;
    logic        write_en = 0;
    logic [5:0]  wr_addr = 0;
    logic [5:0]  rd_addr = 0;
    logic [15:0] data_in = 0;
    logic [15:0] data_out;
    int checks = 0;
    int errors = 0;

    action_ram dut (
        .clk(clk), .rst(rst), .en(en), .write_en(write_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic w,
                        input logic [5:0] wa, input logic [5:0] ra, input logic [15:0] d);
        rst = r; en = e; write_en = w; wr_addr = wa; rd_addr = ra; data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (data_out === exp) else begin
            errors++;
            $error("FAIL %s: data_out=%h expected=%h", tag, data_out, exp);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        check("reset_out", 16'h0);
        step(0, 1, 0, 0, 0, 0);
        check("reset_rd0", 16'h0);
        step(0, 1, 0, 0, 5, 0);
        check("reset_rd5", 16'h0);
        step(0, 1, 0, 0, 63, 0);
        check("reset_rd63", 16'h0);

        step(0, 1, 1, 5, 0, 16'd5);
        step(0, 1, 0, 0, 5, 0);
        check("wr_rd5", 16'd5);
        step(0, 1, 1, 1, 0, 16'd10);
        step(0, 1, 0, 0, 1, 0);
        check("wr_rd1", 16'd10);
        step(0, 1, 0, 0, 5, 0);
        check("reread5", 16'd5);

        step(0, 0, 1, 2, 1, 16'hBEEF);
        check("en0_hold_a", 16'd5);
        step(0, 1, 0, 0, 2, 0);
        check("en0_nowrite", 16'h0);
        step(0, 1, 0, 0, 1, 0);
        check("rd1_again", 16'd10);
        step(0, 0, 0, 0, 5, 0);
        check("en0_hold_b", 16'd10);

        step(0, 1, 1, 7, 0, 16'd3);
        check("rd0_during_wr7", 16'h0);
        step(0, 1, 1, 7, 7, 16'd9);
        check("rdw_old", 16'd3);
        step(0, 1, 0, 0, 7, 0);
        check("rdw_new", 16'd9);

        for (int a = 0; a < 64; a++) step(0, 1, 1, 6'(a), 0, 16'(a + 100));
        for (int a = 0; a < 64; a++) begin
            step(0, 1, 0, 0, 6'(a), 0);
            check($sformatf("b2b_rd%0d", a), 16'(a + 100));
        end

        step(1, 1, 1, 4, 4, 16'd7);
        check("rst_mid_out", 16'h0);
        step(0, 1, 0, 0, 4, 0);
        check("rst_mid_mem4", 16'h0);
        step(0, 1, 0, 0, 63, 0);
        check("rst_mid_mem63", 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/action_ram.md
Name: action_ram

Overview:
- Simple dual-port synchronous RAM: one write port, one read port, single clock. Default 64 words x 16 bits.
- Stores per-state action entries for the reinforcement-learning datapath. The agent writes an action word at one address while reading another.
- Registered read output; synchronous clear of the whole array on reset.

Parameters:
- DATA_WIDTH, 16, width of each stored word and of data_in/data_out
- ADDR_WIDTH, 6, width of wr_addr/rd_addr
- DEPTH, 2**ADDR_WIDTH (64), number of words; all addresses 0..DEPTH-1 are valid

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  port enable; gates both read and write
- write_en  input  1  write strobe; effective only when en=1
- wr_addr  input  ADDR_WIDTH  write address
- rd_addr  input  ADDR_WIDTH  read address
- data_in  input  DATA_WIDTH  write data
- data_out  output  DATA_WIDTH  registered read data

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array held in flops or inferred RAM. Reset clear must be supported; flop implementation is acceptable.
- Reset: on a rising edge with rst=1, all DEPTH words become 0 and data_out becomes 0. rst has priority over en and write_en. Reset asserted mid-operation discards any write in that cycle.
- Write: on a rising edge with rst=0, en=1 and write_en=1, mem[wr_addr] <= data_in. Otherwise memory is unchanged.
- Read: on a rising edge with rst=0 and en=1, data_out <= mem[rd_addr]. This read happens regardless of write_en. Read latency is 1 cycle: rd_addr presented before edge N gives data on data_out after edge N.
- en=0: no write, no read; data_out holds its last value.
- Read-during-write, same address (wr_addr==rd_addr, en=1, write_en=1): data_out gets the OLD stored word (read-first). The new word is visible on the following read.
- Different addresses in the same cycle: both operations complete independently.
- Addresses are full-range; there is no out-of-range case and no wrap logic.
- No handshake, no busy, no error outputs; every cycle may carry a new read and a new write.
- data_out is never X after the first reset.

Test Plan:
- Reset: rst=1 for 1 cycle, then en=1, read addresses 0, 5, 63 -> data_out=0 for each, 1 cycle after each address.
- Write then read: en=1, write_en=1, wr_addr=5, data_in=5 for one edge; next cycle write_en=0, rd_addr=5 -> data_out=5 after the following edge. Then write addr 1 = 10, read addr 1 -> data_out=10; re-read addr 5 -> still 5.
- Enable gating: en=0, write_en=1, wr_addr=2, data_in=16'hBEEF -> no write. Then en=1, read addr 2 -> 0. With en=0 and rd_addr changed, data_out holds its prior value.
- Read-during-write: mem[7]=3; en=1, write_en=1, wr_addr=7, rd_addr=7, data_in=9 -> data_out=3 after that edge; next edge reading 7 -> 9.
- Boundary/back-to-back: write addresses 0..63 with data=addr+100 on consecutive cycles, then read 0..63 back-to-back -> data_out = addr+100 each cycle with 1-cycle latency; addr 63 -> 163.
- Reset mid-operation: rst=1 coincident with write_en=1, wr_addr=4, data_in=7 -> mem[4]=0 and data_out=0 afterwards.
